mul_share_arbiter: RTL

//  Shares one Booth multiplier (multiplier_top) between two requesters, e.g. the integer

---
 rtl/mul_share_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
//   Shares one multiplier between two requesters. Requests are granted
//   round-robin. The accepted operands are held on mul_M/mul_Q, a one-cycle
//   start pulse is sent, and the block waits for done under a watchdog.
//   The selected half of the product is returned over a tagged
//   valid/ready response channel.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready [1:0]  per-requester request handshake
//   req_a0/req_b0, req_a1/b1   operands (M, Q) from requester 0 / 1
//   req_hi [1:0]               per requester: 1 = upper product half
//   mul_start, mul_M, mul_Q    multiplier launch pulse and operands
//   mul_result, mul_done       multiplier product and completion flag
//   resp_valid/resp_ready      response handshake
//   resp_id, resp_data         requester tag and selected product half
//   resp_err                   watchdog expired, resp_data forced to 0
module mul_share_arbiter #(
    parameter int N       = 16,
    parameter int TIMEOUT = 2*N+8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [N-1:0]   req_a0,
    input  logic [N-1:0]   req_b0,
    input  logic [N-1:0]   req_a1,
    input  logic [N-1:0]   req_b1,
    input  logic [1:0]     req_hi,
    output logic           mul_start,
    output logic [N-1:0]   mul_M,
    output logic [N-1:0]   mul_Q,
    input  logic [2*N-1:0] mul_result,
    input  logic           mul_done,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic           resp_id,
    output logic [N-1:0]   resp_data,
    output logic           resp_err
);

    localparam int WW = $clog2(TIMEOUT) + 1;
    localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_BUSY   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]    state;
    logic          rr_ptr;
    logic          hi_q;
    logic          armed;
    logic [WW-1:0] wdog;
    logic          any_valid;
    logic          grant;

    // Favoured requester wins if it is asking, otherwise the other one.
    always_comb begin
        any_valid = |req_valid;
        grant     = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
        req_ready = 2'b00;
        if (state == S_IDLE && any_valid)
            req_ready[grant] = 1'b1;
    end

    assign mul_start  = (state == S_LAUNCH);
    assign resp_valid = (state == S_RESP);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            rr_ptr    <= 1'b0;
            hi_q      <= 1'b0;
            armed     <= 1'b0;
            wdog      <= '0;
            mul_M     <= '0;
            mul_Q     <= '0;
            resp_id   <= 1'b0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        mul_M   <= grant ? req_a1 : req_a0;
                        mul_Q   <= grant ? req_b1 : req_b0;
                        hi_q    <= req_hi[grant];
                        resp_id <= grant;
                        rr_ptr  <= ~grant;
                        state   <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    wdog  <= '0;
                    armed <= 1'b0;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    // A done still high from the previous operation must be
                    // seen low once before it can count as completion.
                    if (!mul_done)
                        armed <= 1'b1;
                    if (armed && mul_done) begin
                        resp_data <= hi_q ? mul_result[2*N-1:N] : mul_result[N-1:0];
                        resp_err  <= 1'b0;
                        state     <= S_RESP;
                    end else if (wdog == WDOG_LAST) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                S_RESP: begin
                    if (resp_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
